// File: rtl/key_pkg.sv
// rtl/key_pkg.sv - shared state encoding and default timing for the key conditioner
package key_pkg;

  typedef enum logic [1:0] {
    S_UP,
    S_DOWN_WAIT,
    S_DOWN,
    S_UP_WAIT
  } key_state_e;

  // 5 ms debounce and 1 s long-press at a 50 MHz clock
  localparam int DEFAULT_DEBOUNCE_CYCLES = 250000;
  localparam int DEFAULT_LONG_CYCLES     = 50000000;

endpackage

// File: rtl/key_conditioner_if.sv
// rtl/key_conditioner_if.sv - raw key pins and conditioned key events
interface key_conditioner_if #(
  parameter int N_KEYS = 3
);

  logic [N_KEYS-1:0] i_keys;
  logic [N_KEYS-1:0] o_level;
  logic [N_KEYS-1:0] o_press;
  logic [N_KEYS-1:0] o_release;
  logic [N_KEYS-1:0] o_long;

  modport master (
    output i_keys,
    input  o_level,
    input  o_press,
    input  o_release,
    input  o_long
  );

  modport slave (
    input  i_keys,
    output o_level,
    output o_press,
    output o_release,
    output o_long
  );

endinterface

// File: rtl/key_channel.sv
// rtl/key_channel.sv - synchroniser, debounce FSM and press/release/long pulses for one key
module key_channel
  import key_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int LONG_CYCLES     = DEFAULT_LONG_CYCLES,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_key,
  output logic o_level,
  output logic o_press,
  output logic o_release,
  output logic o_long
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HW = $clog2(LONG_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST  = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_CYCLES);

  logic [1:0]    sync;
  logic          pressed;
  key_state_e    state;
  logic [CW-1:0] cnt;
  logic [HW-1:0] hold;
  logic          long_flag;

  assign pressed = sync[1] ^ ACTIVE_LOW;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sync      <= {2{ACTIVE_LOW}};
      state     <= S_UP;
      cnt       <= '0;
      hold      <= '0;
      long_flag <= 1'b0;
      o_level   <= 1'b0;
      o_press   <= 1'b0;
      o_release <= 1'b0;
      o_long    <= 1'b0;
    end else begin
      sync      <= {sync[0], i_key};
      o_press   <= 1'b0;
      o_release <= 1'b0;
      o_long    <= 1'b0;
      case (state)
        S_UP: begin
          if (pressed) begin
            state <= S_DOWN_WAIT;
            cnt   <= '0;
          end
        end
        S_DOWN_WAIT: begin
          if (!pressed) begin
            state <= S_UP;
          end else if (cnt == CNT_LAST) begin
            state     <= S_DOWN;
            o_press   <= 1'b1;
            o_level   <= 1'b1;
            hold      <= '0;
            long_flag <= 1'b0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_DOWN: begin
          if (!pressed) begin
            state <= S_UP_WAIT;
            cnt   <= '0;
          end else begin
            // saturate so the long pulse can never re-arm on a very long hold
            if (hold != HOLD_MAX) hold <= hold + HW'(1);
            if (hold == HOLD_LAST && !long_flag) begin
              o_long    <= 1'b1;
              long_flag <= 1'b1;
            end
          end
        end
        S_UP_WAIT: begin
          if (pressed) begin
            state <= S_DOWN;
          end else if (cnt == CNT_LAST) begin
            state     <= S_UP;
            o_release <= 1'b1;
            o_level   <= 1'b0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= S_UP;
      endcase
    end
  end

endmodule

// File: rtl/key_conditioner.sv
// rtl/key_conditioner.sv - debounced level and event pulses for N_KEYS independent push-buttons
module key_conditioner
  import key_pkg::*;
#(
  parameter int N_KEYS          = 3,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int LONG_CYCLES     = DEFAULT_LONG_CYCLES,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input logic              i_clk,
  input logic              i_rst,
  key_conditioner_if.slave bus
);

  if (N_KEYS < 1 || DEBOUNCE_CYCLES < 1 || LONG_CYCLES < 1) begin : g_bad_params
    $fatal(1, "key_conditioner: N_KEYS, DEBOUNCE_CYCLES and LONG_CYCLES must be >= 1");
  end

  logic [N_KEYS-1:0] level;
  logic [N_KEYS-1:0] press;
  logic [N_KEYS-1:0] rel;
  logic [N_KEYS-1:0] lng;

  for (genvar g = 0; g < N_KEYS; g++) begin : g_ch
    key_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .LONG_CYCLES    (LONG_CYCLES),
      .ACTIVE_LOW     (ACTIVE_LOW)
    ) u_ch (
      .i_clk    (i_clk),
      .i_rst    (i_rst),
      .i_key    (bus.i_keys[g]),
      .o_level  (level[g]),
      .o_press  (press[g]),
      .o_release(rel[g]),
      .o_long   (lng[g])
    );
  end

  assign bus.o_level   = level;
  assign bus.o_press   = press;
  assign bus.o_release = rel;
  assign bus.o_long    = lng;

endmodule

// File: tb/tb_key_conditioner.sv
// tb/tb_key_conditioner.sv - directed bench for key_conditioner (debounce 4, long 20, active-low)
module tb_key_conditioner;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  key_conditioner_if #(.N_KEYS(3)) bus ();

  key_conditioner #(
    .N_KEYS         (3),
    .DEBOUNCE_CYCLES(4),
    .LONG_CYCLES    (20),
    .ACTIVE_LOW     (1'b1)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // {level, press, release, long}, 3 bits each
  logic [11:0] obs;
  assign obs = {bus.o_level, bus.o_press, bus.o_release, bus.o_long};

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    bus.i_keys = 3'b111;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (obs !== 12'h000) begin
        bad++;
        $display("FAIL reset i=%0d got=%h exp=%h", i, obs, 12'h000);
      end
    end
    rst = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_clean_press;
    logic [11:0] exp;
    bus.i_keys[0] = 1'b0;
    for (int e = 1; e <= 12; e++) begin
      tick();
      exp = {(e >= 7) ? 3'b001 : 3'b000, (e == 7) ? 3'b001 : 3'b000, 3'b000, 3'b000};
      total++;
      if (obs !== exp) begin
        bad++;
        $display("FAIL clean_press e=%0d got=%h exp=%h", e, obs, exp);
      end
    end
    bus.i_keys[0] = 1'b1;
    for (int e = 1; e <= 10; e++) begin
      tick();
      exp = {(e < 7) ? 3'b001 : 3'b000, 3'b000, (e == 7) ? 3'b001 : 3'b000, 3'b000};
      total++;
      if (obs !== exp) begin
        bad++;
        $display("FAIL clean_release e=%0d got=%h exp=%h", e, obs, exp);
      end
    end
  endtask

  task automatic test_bounce;
    for (int i = 0; i < 30; i++) begin
      bus.i_keys[0] = ((i / 2) % 2) != 0;
      tick();
      total++;
      if (obs !== 12'h000) begin
        bad++;
        $display("FAIL bounce i=%0d got=%h exp=%h", i, obs, 12'h000);
      end
    end
    bus.i_keys[0] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      total++;
      if (obs !== 12'h000) begin
        bad++;
        $display("FAIL bounce_settle i=%0d got=%h exp=%h", i, obs, 12'h000);
      end
    end
  endtask

  task automatic test_long_press;
    logic [11:0] exp;
    bus.i_keys[1] = 1'b0;
    for (int e = 1; e <= 40; e++) begin
      tick();
      exp = {(e >= 7) ? 3'b010 : 3'b000, (e == 7) ? 3'b010 : 3'b000, 3'b000,
             (e == 27) ? 3'b010 : 3'b000};
      total++;
      if (obs !== exp) begin
        bad++;
        $display("FAIL long_press e=%0d got=%h exp=%h", e, obs, exp);
      end
    end
    bus.i_keys[1] = 1'b1;
    for (int e = 1; e <= 10; e++) begin
      tick();
      exp = {(e < 7) ? 3'b010 : 3'b000, 3'b000, (e == 7) ? 3'b010 : 3'b000, 3'b000};
      total++;
      if (obs !== exp) begin
        bad++;
        $display("FAIL long_release e=%0d got=%h exp=%h", e, obs, exp);
      end
    end
  endtask

  task automatic test_release_glitch;
    logic [11:0] exp;
    bus.i_keys[2] = 1'b0;
    for (int e = 1; e <= 8; e++) begin
      tick();
      exp = {(e >= 7) ? 3'b100 : 3'b000, (e == 7) ? 3'b100 : 3'b000, 3'b000, 3'b000};
      total++;
      if (obs !== exp) begin
        bad++;
        $display("FAIL glitch_press e=%0d got=%h exp=%h", e, obs, exp);
      end
    end
    bus.i_keys[2] = 1'b1;
    for (int e = 1; e <= 12; e++) begin
      if (e == 3) bus.i_keys[2] = 1'b0;
      tick();
      exp = {3'b100, 3'b000, 3'b000, 3'b000};
      total++;
      if (obs !== exp) begin
        bad++;
        $display("FAIL glitch_hold e=%0d got=%h exp=%h", e, obs, exp);
      end
    end
    bus.i_keys[2] = 1'b1;
    for (int e = 1; e <= 10; e++) begin
      tick();
      exp = {(e < 7) ? 3'b100 : 3'b000, 3'b000, (e == 7) ? 3'b100 : 3'b000, 3'b000};
      total++;
      if (obs !== exp) begin
        bad++;
        $display("FAIL glitch_release e=%0d got=%h exp=%h", e, obs, exp);
      end
    end
  endtask

  task automatic test_simultaneous;
    logic [11:0] exp;
    bus.i_keys = 3'b010;
    for (int e = 1; e <= 9; e++) begin
      tick();
      exp = {(e >= 7) ? 3'b101 : 3'b000, (e == 7) ? 3'b101 : 3'b000, 3'b000, 3'b000};
      total++;
      if (obs !== exp) begin
        bad++;
        $display("FAIL simultaneous e=%0d got=%h exp=%h", e, obs, exp);
      end
    end
  endtask

  task automatic test_reset_mid_hold;
    logic [11:0] exp;
    rst = 1'b1;
    tick();
    total++;
    if (obs !== 12'h000) begin
      bad++;
      $display("FAIL reset_mid_hold got=%h exp=%h", obs, 12'h000);
    end
    rst = 1'b0;
    for (int e = 1; e <= 9; e++) begin
      tick();
      exp = {(e >= 7) ? 3'b101 : 3'b000, (e == 7) ? 3'b101 : 3'b000, 3'b000, 3'b000};
      total++;
      if (obs !== exp) begin
        bad++;
        $display("FAIL repress e=%0d got=%h exp=%h", e, obs, exp);
      end
    end
    bus.i_keys = 3'b111;
    for (int e = 1; e <= 10; e++) begin
      tick();
      exp = {(e < 7) ? 3'b101 : 3'b000, 3'b000, (e == 7) ? 3'b101 : 3'b000, 3'b000};
      total++;
      if (obs !== exp) begin
        bad++;
        $display("FAIL repress_release e=%0d got=%h exp=%h", e, obs, exp);
      end
    end
  endtask

  initial begin
    bus.i_keys = 3'b111;
    test_reset();
    test_clean_press();
    test_bounce();
    test_long_press();
    test_release_glitch();
    test_simultaneous();
    test_reset_mid_hold();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
